// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding, default payload width and parity-type constants
package uart_tx_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first payload shifter with bit index and last-bit flag
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  cur_bit,
  output logic                  done
);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      idx;
  logic                  primed;

  // The first shift presents bit 0 on the line; later shifts advance the
  // index, so idx always names the payload bit currently being driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      idx    <= '0;
      primed <= 1'b0;
    end else if (load) begin
      shreg  <= data;
      idx    <= '0;
      primed <= 1'b0;
    end else if (shift) begin
      shreg  <= shreg >> 1;
      primed <= 1'b1;
      if (primed) idx <= idx + 1'b1;
    end
  end

  assign cur_bit = shreg[0];
  assign done    = primed && (idx == IDX_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: frame FSM, bit timer, parity and registered serial output
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);
  tx_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q;
  logic [5:0]            presc_q, cnt;
  logic                  tx_n, shift, ser_bit, ser_done;
  logic                  bit_end, accept, parity;

  assign bit_end = (cnt == presc_q - 6'd1);
  assign accept  = DATA_VALID && ((state == IDLE) || ((state == STOP) && bit_end));
  assign parity  = (^data_q) ^ (par_typ_q == PAR_ODD);
  assign busy    = (state != IDLE);

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift   (shift),
    .data    (P_DATA),
    .cur_bit (ser_bit),
    .done    (ser_done)
  );

  // tx_n is the line value for the state being entered, so TX_OUT
  // comes straight from a flop and changes exactly at bit boundaries.
  always_comb begin
    state_n = state;
    tx_n    = TX_OUT;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = ser_bit;
          shift   = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (!ser_done) begin
            tx_n  = ser_bit;
            shift = 1'b1;
          end else if (par_en_q) begin
            state_n = PARITY;
            tx_n    = parity;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = accept ? START : IDLE;
          tx_n    = !accept;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      cnt       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      state  <= state_n;
      TX_OUT <= tx_n;
      if (accept) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        presc_q   <= (Prescale == 6'd0) ? 6'd1 : Prescale;
        cnt       <= '0;
      end else if (state != IDLE) begin
        cnt <= bit_end ? 6'd0 : cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - directed self-checking bench for uart_tx_core
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_core #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_tx"}, TX_OUT, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  // Drives a request at the current falling edge; returns at the falling
  // edge right after the accepting rising edge, DATA_VALID still high.
  task automatic start_req(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic [5:0] presc);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Prescale   = presc;
    DATA_VALID = 1'b1;
    @(negedge clk);
  endtask

  // fr lists line values in transmit order (index 0 = start bit). Sampling
  // begins at the current falling edge and ends on the frame's last cycle.
  task automatic expect_frame(input string tag, input logic [0:10] fr, input int nbits,
                              input int p, input int poke_at, input int limit);
    for (int i = 0; i < nbits * p && i < limit; i++) begin
      if (i > 0) @(negedge clk);
      if (i == poke_at) begin
        P_DATA     = 8'h00;
        PAR_TYP    = 1'b1;
        PAR_EN     = 1'b1;
        Prescale   = 6'd2;
        DATA_VALID = 1'b1;
      end
      if (i == poke_at + 1) DATA_VALID = 1'b0;
      check($sformatf("%s_tx[%0d]", tag, i), TX_OUT, fr[i / p]);
      check($sformatf("%s_busy[%0d]", tag, i), busy, 1'b1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // 0xA5, P=8, no parity: 0,1,0,1,0,0,1,0,1,1 then idle after 80 cycles
    start_req(8'hA5, 1'b0, 1'b0, 6'd8);
    DATA_VALID = 1'b0;
    expect_frame("a5", 11'b01010010110, 10, 8, -10, 1000);
    @(negedge clk);
    check_idle("a5");

    // 0x01, P=8, even parity -> parity bit 1, 88 cycles
    start_req(8'h01, 1'b1, 1'b0, 6'd8);
    DATA_VALID = 1'b0;
    expect_frame("par_even", 11'b01000000011, 11, 8, -10, 1000);
    @(negedge clk);
    check_idle("par_even");

    // 0x01, P=8, odd parity -> parity bit 0
    start_req(8'h01, 1'b1, 1'b1, 6'd8);
    DATA_VALID = 1'b0;
    expect_frame("par_odd", 11'b01000000001, 11, 8, -10, 1000);
    @(negedge clk);
    check_idle("par_odd");

    // back-to-back 0x3C then 0xC3 at P=16, 320 cycles with no gap
    start_req(8'h3C, 1'b0, 1'b0, 6'd16);
    P_DATA = 8'hC3;
    expect_frame("b2b_0", 11'b00011110010, 10, 16, -10, 1000);
    @(negedge clk);
    DATA_VALID = 1'b0;
    expect_frame("b2b_1", 11'b01100001110, 10, 16, -10, 1000);
    @(negedge clk);
    check_idle("b2b");

    // Prescale=0 behaves as 1: 10-cycle frame
    start_req(8'hFF, 1'b0, 1'b0, 6'd0);
    DATA_VALID = 1'b0;
    expect_frame("presc0", 11'b01111111110, 10, 1, -10, 1000);
    @(negedge clk);
    check_idle("presc0");

    // inputs changed and DATA_VALID pulsed mid-frame: frame unaffected, no new frame
    start_req(8'hA5, 1'b0, 1'b0, 6'd8);
    DATA_VALID = 1'b0;
    expect_frame("midchg", 11'b01010010110, 10, 8, 20, 1000);
    @(negedge clk);
    check_idle("midchg");
    @(negedge clk);
    check_idle("midchg_late");

    // reset during DATA bit 3, then a clean frame right after release
    start_req(8'hA5, 1'b0, 1'b0, 6'd8);
    DATA_VALID = 1'b0;
    expect_frame("pre_rst", 11'b01010010110, 10, 8, -10, 35);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_rst");
    reset = 1'b0;
    start_req(8'h3C, 1'b0, 1'b0, 6'd4);
    DATA_VALID = 1'b0;
    expect_frame("post_rst", 11'b00011110010, 10, 4, -10, 1000);
    @(negedge clk);
    check_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port P_DATA, input, DATA_WIDTH bits: the parallel payload, sampled only at acceptance.
REQ-005 The block SHALL have the port DATA_VALID, input, 1 bit: a payload request, level-sensitive.
REQ-006 The block SHALL have the port PAR_EN, input, 1 bit: 1 means a parity bit is inserted; sampled at acceptance.
REQ-007 The block SHALL have the port PAR_TYP, input, 1 bit: 0 means even parity, 1 means odd parity; sampled at acceptance.
REQ-008 The block SHALL have the port Prescale, input, 6 bits: clk cycles per bit period; the value 0 SHALL be treated as 1; sampled at acceptance.
REQ-009 The block SHALL have the port TX_OUT, output, 1 bit: the serial line, idle high, driven directly by a flop.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while a frame is in progress (state not IDLE).

Function
REQ-011 The block SHALL implement the states IDLE, START, DATA, PARITY and STOP, held in a state register.
REQ-012 Acceptance SHALL occur when DATA_VALID=1 and either state=IDLE or the block is in the last cycle of STOP.
- At acceptance, P_DATA, PAR_EN, PAR_TYP and Prescale are latched.
REQ-013 DATA_VALID SHALL be ignored at all other times; latched values SHALL NOT change mid-frame.
REQ-014 An acceptance at edge k SHALL enter START at edge k; TX_OUT=0 and busy=1 from edge k.
REQ-015 Each bit SHALL last exactly P clk cycles, where P is the effective latched Prescale.
- Timing is set by an edge counter that counts 0..P-1 and wraps to 0 at each bit boundary.
REQ-016 After START, the DATA state SHALL send payload bits LSB first.
- A bit index counts 0..DATA_WIDTH-1.
- The state advances after bit DATA_WIDTH-1 completes.
REQ-017 After DATA, the next state SHALL be PARITY when PAR_EN is latched as 1, otherwise STOP.
REQ-018 The parity bit SHALL be the XOR of the latched data for even parity and its inverse for odd parity.
REQ-019 STOP SHALL drive TX_OUT=1 for P cycles.
- At its last cycle, the next state is START when DATA_VALID=1 (back-to-back, no idle gap), otherwise IDLE.
REQ-020 Frame length SHALL be (DATA_WIDTH+2+PAR_EN)*P cycles, with no gap between frames in back-to-back operation.
REQ-021 busy SHALL fall at the edge that enters IDLE and SHALL stay high across a back-to-back boundary.
REQ-022 TX_OUT SHALL change only on clk edges and SHALL be glitch-free; while in IDLE, TX_OUT=1.
REQ-023 Illegal state encodings SHALL return to IDLE on the next edge with TX_OUT=1.

Reset
REQ-024 While reset=1 at a clk edge, the block SHALL set state=IDLE, TX_OUT=1, busy=0, and all counters and latched registers to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame at that edge without emitting a partial stop bit.
- After reset, DATA_VALID is honoured at the first edge with reset=0.

Structure
REQ-026 A shared package uart_tx_pkg SHALL hold the state enumeration, the DATA_WIDTH default and the parity-type constants (EVEN=0, ODD=1).
REQ-027 The shift/bit-index logic SHALL be a single sub-module uart_tx_serializer.
- Inputs: load, shift enable, latched data.
- Outputs: the current bit and a done flag.
REQ-028 The FSM, edge counter, parity computation and output flop SHALL reside in uart_tx_core.

Verification
REQ-029 Prescale=8, PAR_EN=0, P_DATA=0xA5, single DATA_VALID pulse -> the bench SHALL observe:
- TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles;
- busy high for 80 cycles, then busy=0 and TX_OUT=1.
REQ-030 Prescale=8, PAR_EN=1, P_DATA=0x01 -> with PAR_TYP=0 the parity bit SHALL be 1; with PAR_TYP=1 the parity bit SHALL be 0; frame length 88 cycles.
REQ-031 Prescale=16, PAR_EN=0, DATA_VALID held high with 0x3C then 0xC3 -> the bench SHALL observe:
- the second start bit immediately follows the first stop bit;
- busy never drops between the frames;
- total length 320 cycles.
REQ-032 Prescale=0 with P_DATA=0xFF -> each bit SHALL last 1 cycle and the frame SHALL be 10 cycles long.
REQ-033 During a frame, change P_DATA, PAR_TYP and Prescale, then pulse DATA_VALID -> the bench SHALL observe:
- the frame is unchanged;
- no new frame is accepted before the STOP boundary.
REQ-034 Assert reset during DATA bit 3 -> the bench SHALL observe:
- TX_OUT=1 and busy=0 at the next edge;
- a new DATA_VALID after release starts a clean frame with the correct start bit.
